// File: rtl/ad9833_pkg.sv
// Shared AD9833 sweep definitions: control bits,
// waveform encoding, park word and sequencer states.
package ad9833_pkg;

  localparam logic [15:0] CTRL_B28     = 16'h2000;
  localparam logic [15:0] CTRL_RESET   = 16'h0100;
  localparam logic [15:0] CTRL_OPBITEN = 16'h0020;
  localparam logic [15:0] CTRL_DIV2    = 16'h0008;
  localparam logic [15:0] CTRL_MODE    = 16'h0002;

  localparam logic [15:0] PARK_CTRL = CTRL_B28 | CTRL_RESET;
  localparam logic [27:0] PARK_FREQ = 28'h0;

  typedef enum logic [1:0] {
    WAVE_SINE = 2'd0,
    WAVE_TRI  = 2'd1,
    WAVE_SQ   = 2'd2,
    WAVE_SQ2  = 2'd3
  } wave_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_REQ,
    S_WAIT,
    S_DWELL,
    S_NEXT,
    S_PARK,
    S_FIN,
    S_ERR
  } state_e;

  function automatic logic [15:0] ctrl_word(input wave_e w);
    logic [15:0] bits;
    unique case (w)
      WAVE_TRI: bits = CTRL_MODE;
      WAVE_SQ:  bits = CTRL_OPBITEN | CTRL_DIV2;
      WAVE_SQ2: bits = CTRL_OPBITEN;
      default:  bits = 16'h0000;
    endcase
    return CTRL_B28 | bits;
  endfunction

endpackage

// File: rtl/ad9833_sweep_ctrl_if.sv
// Go/ack/complete handshake between the sweep
// sequencer and the AD9833 serial driver.
interface ad9833_sweep_ctrl_if;

  logic        go;
  logic [15:0] control;
  logic [27:0] freq;
  logic        good_to_reset_go;
  logic        send_complete;

  modport master (
    output go,
    output control,
    output freq,
    input  good_to_reset_go,
    input  send_complete
  );

  modport slave (
    input  go,
    input  control,
    input  freq,
    output good_to_reset_go,
    output send_complete
  );

endinterface

// File: rtl/ad9833_dwell_timer.sv
// Dwell down-counter: load, count to zero, expire.
// Abort ends a running count on the current cycle.
module ad9833_dwell_timer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         abort,
  output logic         expire
);

  logic [W-1:0] cnt;
  logic         run;

  assign expire = run && (abort || cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (load) begin
      cnt <= load_val;
      run <= 1'b1;
    end else if (expire) begin
      run <= 1'b0;
    end else if (run) begin
      cnt <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/ad9833_sweep_ctrl.sv
// Frequency-sweep sequencer feeding the AD9833 driver:
// one transaction per point, dwell, then a park write.
module ad9833_sweep_ctrl
  import ad9833_pkg::*;
#(
  parameter int DWELL_W     = 24,
  parameter int ACK_TIMEOUT = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [27:0]        freq_start,
  input  logic [27:0]        freq_step,
  input  logic [15:0]        num_steps,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [1:0]         wave,
  ad9833_sweep_ctrl_if.master drv,
  output logic               busy,
  output logic               done,
  output logic               ovf,
  output logic               err,
  output logic [15:0]        point_idx
);

  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  state_e             state;
  logic               go_q;
  logic [15:0]        ctrl_q;
  logic [27:0]        freq_q;
  logic [27:0]        step_q;
  logic [15:0]        nsteps_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               is_park;
  logic               stop_pend;
  logic [TO_W-1:0]    to_cnt;
  logic [28:0]        sum;
  logic               tmr_load;
  logic               tmr_expire;

  assign drv.go      = go_q;
  assign drv.control = ctrl_q;
  assign drv.freq    = freq_q;

  // 29-bit add: the carry flags a point past 2^28-1
  assign sum = {1'b0, freq_q} + {1'b0, step_q};

  assign tmr_load = (state == S_WAIT) && drv.send_complete && !is_park;

  ad9833_dwell_timer #(
    .W(DWELL_W)
  ) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (dwell_q),
    .abort    (stop || stop_pend),
    .expire   (tmr_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      go_q      <= 1'b0;
      ctrl_q    <= PARK_CTRL;
      freq_q    <= PARK_FREQ;
      step_q    <= '0;
      nsteps_q  <= '0;
      dwell_q   <= '0;
      is_park   <= 1'b0;
      stop_pend <= 1'b0;
      to_cnt    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ovf       <= 1'b0;
      err       <= 1'b0;
      point_idx <= '0;
    end else begin
      done <= 1'b0;
      if (stop && state != S_IDLE) stop_pend <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            ctrl_q    <= ctrl_word(wave_e'(wave));
            freq_q    <= freq_start;
            step_q    <= freq_step;
            nsteps_q  <= num_steps;
            dwell_q   <= dwell;
            point_idx <= '0;
            is_park   <= 1'b0;
            stop_pend <= 1'b0;
            ovf       <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b1;
            state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          go_q   <= 1'b1;
          to_cnt <= '0;
          state  <= S_REQ;
        end
        S_REQ: begin
          if (drv.good_to_reset_go) begin
            go_q  <= 1'b0;
            state <= S_WAIT;
          end else if (to_cnt == TO_LAST) begin
            go_q  <= 1'b0;
            err   <= 1'b1;
            done  <= 1'b1;
            state <= S_ERR;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        S_WAIT: begin
          if (drv.send_complete) begin
            if (is_park) begin
              done  <= 1'b1;
              state <= S_FIN;
            end else begin
              state <= S_DWELL;
            end
          end
        end
        S_DWELL: begin
          if (tmr_expire) state <= S_NEXT;
        end
        S_NEXT: begin
          if (stop_pend || point_idx == nsteps_q) begin
            ctrl_q <= PARK_CTRL;
            freq_q <= PARK_FREQ;
            state  <= S_PARK;
          end else if (sum[28]) begin
            ovf    <= 1'b1;
            ctrl_q <= PARK_CTRL;
            freq_q <= PARK_FREQ;
            state  <= S_PARK;
          end else begin
            freq_q    <= sum[27:0];
            point_idx <= point_idx + 16'd1;
            state     <= S_LOAD;
          end
        end
        S_PARK: begin
          is_park <= 1'b1;
          go_q    <= 1'b1;
          to_cnt  <= '0;
          state   <= S_REQ;
        end
        S_FIN, S_ERR: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ad9833_sweep_ctrl.md
# ad9833_sweep_ctrl

Frequency-sweep sequencer directly upstream of the AD9833 serial driver. Takes a start frequency, step, step count, dwell time and waveform. Issues one driver transaction (control + 28-bit frequency) per sweep point using the driver's go / good_to_reset_go / send_complete handshake. Holds each point for a programmed dwell, then ends with a reset/park write.

## Interface
- `DWELL_W`, 24: width of the dwell counter, in clk cycles.
- `ACK_TIMEOUT`, 1000: cycles to wait for `good_to_reset_go` after raising `go`; a missing ack is an error.
- `clk` in 1: system clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request to begin a sweep; ignored unless idle.
- `stop` in 1: one-cycle request to end the sweep early.
- `freq_start` in 28: first frequency word.
- `freq_step` in 28: unsigned increment per point.
- `num_steps` in 16: increments after the first point; total points = `num_steps`+1.
- `dwell` in `DWELL_W`: hold cycles after each `send_complete`.
- `wave` in 2: 0 sine, 1 triangle, 2 square, 3 square/2.
- `good_to_reset_go` in 1: driver ack.
- `send_complete` in 1: driver one-cycle completion pulse.
- `go` out 1: transaction request to the driver.
- `control` out 16: control word to the driver.
- `freq` out 28: frequency word to the driver.
- `busy` out 1: high whenever not IDLE.
- `done` out 1: one-cycle pulse at sweep end.
- `ovf` out 1: sticky; the next frequency would exceed 2^28−1; cleared on `start`.
- `err` out 1: sticky; ack timeout occurred; cleared on `start`.
- `point_idx` out 16: index of the current point.

## Operation
- `start`, `freq_start`, `freq_step`, `num_steps`, `dwell` and `wave` are latched on accepted `start` and never re-read during a sweep.
- Control word = 0x2000 (B28) | wave bits:
  - sine 0x0000
  - triangle 0x0002
  - square 0x0028
  - square/2 0x0020
- Park write: `control`=0x2100 (B28|RESET), `freq`=0.
- States:
  - IDLE: `start` → LOAD.
  - LOAD: drive `control`/`freq` for the point → REQ.
  - REQ: `go`=1; `good_to_reset_go` → WAIT; timeout → ERR.
  - WAIT: `send_complete` → DWELL, or → FIN if this was the park write.
  - DWELL: count `dwell` cycles, then → NEXT.
  - NEXT: if stop pending or `point_idx`==`num_steps` → PARK.
  - NEXT: else if `freq`+`freq_step` > 2^28−1, set `ovf` → PARK.
  - NEXT: else `freq`+=`freq_step`, `point_idx`+=1 → LOAD.
  - PARK: load the park word → REQ, flagged as park.
  - FIN: `done`=1 → IDLE.
  - ERR: `err`=1, `go`=0, `done`=1 → IDLE (no park write; the driver state is unknown).
- Addition is 29-bit, and the carry decides overflow; `freq` never wraps.
- `stop` is registered into a pending flag and acted on only in NEXT. A transfer in progress always completes. A `stop` during DWELL aborts the remaining dwell and goes → NEXT next cycle.
- `start` while busy is ignored. `start` and `stop` together in IDLE: start wins and the stop is dropped.
- `send_complete` or `good_to_reset_go` outside REQ/WAIT: ignored.
- `dwell`=0: DWELL lasts 1 cycle.
- `num_steps`=0: one point, then park.

## Timing
- Reset values:
  - `go`=0, `busy`=0, `done`=0, `ovf`=0, `err`=0, `point_idx`=0.
  - `control`=0x2100, `freq`=0.
  - state IDLE.
- Reset mid-sweep drops `go` immediately. The downstream driver has no reset, so the bench must not assert a new `go` until it has returned to idle.
- `start` sampled at edge N: `busy`=1 at N+1; `go`=1 at N+2, with `control`/`freq` valid at N+1.
- `control`/`freq` are stable from one cycle before `go` rises until the cycle after `send_complete`.
- `go` falls the cycle after `good_to_reset_go` is sampled high. The timeout counter counts cycles in REQ; it reaches `ACK_TIMEOUT` → ERR.
- `send_complete` at edge M: DWELL from M+1; next `go` at M+1+`dwell`+3 (NEXT, LOAD, REQ).
- `done` is high the cycle after park `send_complete`; `busy` falls on the same edge as `done` falls.

## Structure
- Shared package `ad9833_pkg`: control-bit constants (B28, RESET, OPBITEN, DIV2, MODE), the wave encoding, the park word, and the state enum.
- One sub-module, `ad9833_dwell_timer`: load/count/expire down-counter with abort input, width `DWELL_W`.

## Test plan
- **Basic 3-point sweep.** `freq_start`=0x0001000, step=0x0000100, `num_steps`=2, `dwell`=10, sine, driver model acking. Required response:
  - `freq` sequence 0x0001000, 0x0001100, 0x0001200, then park 0.
  - `control`=0x2000 ×3, then 0x2100.
  - one `done` pulse.
- **Overflow.** `freq_start`=0xFFFFF00, step=0x0000200, `num_steps`=5. Required response: 1 point, `ovf`=1, park write, `done`.
- **Early stop.** `stop` pulsed during point 1 transfer, `num_steps`=10. Required response: transfer 1 completes, no point 2, park write, `done`, `point_idx`=1.
- **Ack timeout.** Driver model never raises `good_to_reset_go`, `ACK_TIMEOUT`=50. Required response: `go` drops at cycle 50 of REQ, `err`=1, `done` pulse, no park write.
- **Reset mid-DWELL.** Assert `rst` during DWELL. Required response: all outputs at reset values the same cycle; a new `start` after reset yields a clean sweep with `ovf`/`err` clear.
- **Edge cases.** `num_steps`=0 with `dwell`=0 and wave=3. Required response: one write with `control`=0x2020, then park; `start` pulses during busy are ignored.
